// File: rtl/fht_frame_sequencer_pkg.sv
// Shared types for the FHT frame sequencer: FSM states, bank count, address bit-reverse.
package fht_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } seq_state_e;

  localparam int BANKS = 4;

  // Reverses the low w bits of v; bits at and above w come back zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fht_seq_skid.sv
// Two-entry valid/ready buffer for FHT read data; the producer only pushes when a slot is free.
module fht_seq_skid #(
  parameter int W = 17
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;
  logic              pop;

  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fht_frame_sequencer.sv
// Frame controller around fht_top: scatter-load, start, wait for done, ordered unload.
// Build option FHT_SEQ_BITREV_EN: bit-reversed read addresses (natural order); else raw RAM order.
import fht_frame_sequencer_pkg::*;

module fht_frame_sequencer #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iS_VALID,
  input  logic [D_BIT-1:0] iS_DATA,
  output logic             oS_READY,
  output logic             oM_VALID,
  output logic [D_BIT-1:0] oM_DATA,
  input  logic             iM_READY,
  output logic             oM_LAST,
  output logic             oFHT_START,
  output logic [BANKS-1:0] oFHT_WE,
  output logic [D_BIT-1:0] oFHT_DATA,
  output logic [A_BIT-1:0] oFHT_ADDR_WR,
  output logic [A_BIT-1:0] oFHT_ADDR_RD,
  input  logic [D_BIT-1:0] iFHT_DATA_0,
  input  logic [D_BIT-1:0] iFHT_DATA_1,
  input  logic [D_BIT-1:0] iFHT_DATA_2,
  input  logic [D_BIT-1:0] iFHT_DATA_3,
  input  logic             iFHT_RDY,
  output logic             oBUSY,
  output logic             oFRAME_DONE
);

  localparam int              CW       = A_BIT + 2;
  localparam logic [CW-1:0]   LAST_IDX = '1;

  seq_state_e                 state;
  logic [CW-1:0]              cnt;
  logic                       armed, rd_done, rdy_q, rdy_p;
  logic [RD_LAT:1]            vld_pipe, last_pipe;
  logic [RD_LAT:1][1:0]       bank_pipe;
  logic [D_BIT-1:0]           rd_data;
  logic [D_BIT:0]             head;
  logic [1:0]                 occ;
  logic [2:0]                 inflight;
  logic [A_BIT-1:0]           raddr;
  logic                       s_hs, m_pop, rd_go;

  assign oS_READY = armed && (state == ST_LOAD);
  assign oBUSY    = (state == ST_START) || (state == ST_WAIT);
  assign s_hs     = iS_VALID & oS_READY;
  assign m_pop    = oM_VALID & iM_READY;
  assign oM_DATA  = head[D_BIT-1:0];
  assign oM_LAST  = oM_VALID & head[D_BIT];

`ifdef FHT_SEQ_BITREV_EN
  assign raddr = A_BIT'(bit_rev(32'(cnt[CW-1:2]), A_BIT));
`else
  assign raddr = cnt[CW-1:2];
`endif

  // Credit check counts the slot freed by a pop this cycle, which keeps RD_LAT=1 at full rate.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= RD_LAT; k++) inflight = inflight + {2'b0, vld_pipe[k]};
    rd_go = (state == ST_UNLOAD) && !rd_done &&
            (({1'b0, occ} + inflight) < (3'd2 + {2'b0, m_pop}));
  end

  always_comb begin
    rd_data = iFHT_DATA_0;
    case (bank_pipe[RD_LAT])
      2'd1:    rd_data = iFHT_DATA_1;
      2'd2:    rd_data = iFHT_DATA_2;
      2'd3:    rd_data = iFHT_DATA_3;
      default: rd_data = iFHT_DATA_0;
    endcase
  end

  fht_seq_skid #(.W(D_BIT + 1)) u_skid (
    .gclk      (iCLK),
    .grst_n    (iRESET),
    .push      (vld_pipe[RD_LAT]),
    .push_data ({last_pipe[RD_LAT], rd_data}),
    .out_ready (iM_READY),
    .out_valid (oM_VALID),
    .out_data  (head),
    .occ       (occ)
  );

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state        <= ST_LOAD;
      cnt          <= '0;
      armed        <= 1'b0;
      rd_done      <= 1'b0;
      rdy_q        <= 1'b0;
      rdy_p        <= 1'b0;
      vld_pipe     <= '0;
      last_pipe    <= '0;
      bank_pipe    <= '0;
      oFHT_START   <= 1'b0;
      oFHT_WE      <= '0;
      oFHT_DATA    <= '0;
      oFHT_ADDR_WR <= '0;
      oFHT_ADDR_RD <= '0;
      oFRAME_DONE  <= 1'b0;
    end else begin
      armed       <= 1'b1;
      rdy_q       <= iFHT_RDY;
      rdy_p       <= rdy_q;
      oFHT_WE     <= '0;
      oFHT_START  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      vld_pipe[1]  <= rd_go;
      last_pipe[1] <= (cnt == LAST_IDX);
      bank_pipe[1] <= cnt[1:0];
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
        bank_pipe[k] <= bank_pipe[k-1];
      end
      case (state)
        ST_LOAD: if (s_hs) begin
          oFHT_WE      <= 4'b0001 << cnt[1:0];
          oFHT_ADDR_WR <= cnt[CW-1:2];
          oFHT_DATA    <= iS_DATA;
          if (cnt == LAST_IDX) begin
            cnt   <= '0;
            state <= ST_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_START: begin
          oFHT_START <= 1'b1;
          state      <= ST_WAIT;
        end
        // Only a fresh rising edge counts, so a done level left over from the last frame is ignored.
        ST_WAIT: if (rdy_q && !rdy_p) state <= ST_UNLOAD;
        ST_UNLOAD: begin
          if (rd_go) begin
            oFHT_ADDR_RD <= raddr;
            if (cnt == LAST_IDX) begin
              cnt     <= '0;
              rd_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (m_pop && oM_LAST) begin
            oFRAME_DONE <= 1'b1;
            state       <= ST_LOAD;
            rd_done     <= 1'b0;
            cnt         <= '0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_frame_sequencer.sv
// Directed bench: two sequencers (RD_LAT 1 and 3) share stimulus; each has its own RAM model.
module tb_fht_frame_sequencer;

  localparam int D = 16;
  localparam int A = 3;
  localparam int N = 32;
  localparam bit PAT[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1, s_valid = 1'b0, m_ready = 1'b1, fht_rdy = 1'b0;
  logic [D-1:0] s_data = '0;
  bit           stall_mode = 1'b0;
  bit           full_rate[2];

  logic         s_ready[2], m_valid[2], m_last[2], start[2], busy[2], done[2];
  logic [D-1:0] m_data[2], fdata[2];
  logic [D-1:0] rdata[2][4];
  logic [3:0]   we[2];
  logic [A-1:0] awr[2], ard[2], a1, a2;
  logic [D-1:0] mem[2][4][8];
  logic [D-1:0] sent[N], exp_out[N];
  logic [D-1:0] got[2][N];
  int           rtab[8];
  int           checks = 0, errors = 0, cyc = 0;
  int           frames[2], starts[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  fht_frame_sequencer #(.D_BIT(D), .A_BIT(A), .RD_LAT(1)) u_dut1 (
    .iCLK(clk), .iRESET(rst_n), .iS_VALID(s_valid), .iS_DATA(s_data), .oS_READY(s_ready[0]),
    .oM_VALID(m_valid[0]), .oM_DATA(m_data[0]), .iM_READY(m_ready), .oM_LAST(m_last[0]),
    .oFHT_START(start[0]), .oFHT_WE(we[0]), .oFHT_DATA(fdata[0]), .oFHT_ADDR_WR(awr[0]),
    .oFHT_ADDR_RD(ard[0]), .iFHT_DATA_0(rdata[0][0]), .iFHT_DATA_1(rdata[0][1]),
    .iFHT_DATA_2(rdata[0][2]), .iFHT_DATA_3(rdata[0][3]), .iFHT_RDY(fht_rdy),
    .oBUSY(busy[0]), .oFRAME_DONE(done[0]));

  fht_frame_sequencer #(.D_BIT(D), .A_BIT(A), .RD_LAT(3)) u_dut3 (
    .iCLK(clk), .iRESET(rst_n), .iS_VALID(s_valid), .iS_DATA(s_data), .oS_READY(s_ready[1]),
    .oM_VALID(m_valid[1]), .oM_DATA(m_data[1]), .iM_READY(m_ready), .oM_LAST(m_last[1]),
    .oFHT_START(start[1]), .oFHT_WE(we[1]), .oFHT_DATA(fdata[1]), .oFHT_ADDR_WR(awr[1]),
    .oFHT_ADDR_RD(ard[1]), .iFHT_DATA_0(rdata[1][0]), .iFHT_DATA_1(rdata[1][1]),
    .iFHT_DATA_2(rdata[1][2]), .iFHT_DATA_3(rdata[1][3]), .iFHT_RDY(fht_rdy),
    .oBUSY(busy[1]), .oFRAME_DONE(done[1]));

  // RAM models: identity "transform"; latency 1 reads the address combinationally, latency 3 via two regs.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      for (int b = 0; b < 4; b++)
        if (we[g][b]) mem[g][b][awr[g]] <= fdata[g];
    a1 <= ard[1];
    a2 <= a1;
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rdata[0][b] = mem[0][b][ard[0]];
      rdata[1][b] = mem[1][b][a2];
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = stall_mode ? PAT[cyc % 4] : 1'b1;
    cyc = cyc + 1;
  end

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int EXP_LAT = (g == 0) ? 2 : 4;
    int           widx, idx, lat, gaps;
    bit           lat_on, busy_q, stall_q, last_q, prev_last_wr, seen;
    logic [D-1:0] data_q;
    always @(negedge clk) begin
      if (!rst_n) begin
        widx = 0; idx = 0; lat = 0; gaps = 0;
        lat_on = 0; busy_q = 0; stall_q = 0; last_q = 0; prev_last_wr = 0; seen = 0;
      end else begin
        if (start[g]) begin
          starts[g]++;
          chk("start_after_writes", widx, N);
          chk("start_follows_last_wr", prev_last_wr, 1);
        end
        prev_last_wr = (we[g] == 4'b1000) && (awr[g] == 3'd7);
        if (we[g] != 4'b0000) begin
          chk("wr_we", we[g], 4'b0001 << (widx % 4));
          chk("wr_addr", awr[g], widx / 4);
          chk("wr_data", fdata[g], sent[widx % N]);
          widx++;
        end
        if (stall_q) begin
          chk("stall_valid", m_valid[g], 1);
          chk("stall_data", m_data[g], data_q);
        end
        stall_q = m_valid[g] && !m_ready;
        data_q  = m_data[g];
        if (last_q || done[g]) chk("frame_done", done[g], last_q);
        if (done[g]) begin
          frames[g]++;
          chk("out_count", idx, N);
          idx = 0;
          widx = 0;
        end
        last_q = 0;
        if (busy_q && !busy[g]) begin
          lat = 0; lat_on = 1;
        end else if (lat_on) begin
          lat++;
          if (m_valid[g]) begin
            chk("first_valid_lat", lat, EXP_LAT);
            lat_on = 0; seen = 1;
          end
        end
        busy_q = busy[g];
        if (seen && !m_valid[g]) gaps++;
        if (m_valid[g] && m_ready) begin
          if (idx < N) begin
            chk("out_data", m_data[g], exp_out[idx]);
            got[g][idx] = m_data[g];
          end
          chk("out_last", m_last[g], idx == N - 1);
          if (idx == N - 1) begin
            last_q = 1;
            if (full_rate[g]) chk("full_rate_gaps", gaps, 0);
            seen = 0; gaps = 0;
          end
          idx++;
        end
      end
    end
  end

  task automatic build_exp();
    for (int k = 0; k < N; k++) exp_out[k] = sent[4 * rtab[k / 4] + k % 4];
  endtask

  // Call at posedge+1; leaves at posedge+1 after the last handshake.
  task automatic send(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      s_valid = 1'b1;
      s_data  = sent[i];
      @(negedge clk);
      chk("s_ready", s_ready[0], 1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int f);
    for (int i = 0; i < 600; i++) begin
      if (frames[0] >= f && frames[1] >= f) break;
      @(negedge clk);
    end
    chk("frame_timeout", (frames[0] >= f) && (frames[1] >= f), 1);
  endtask

  task automatic rdy_pulse(input int low_cycles);
    @(posedge clk); #1 fht_rdy = 1'b0;
    repeat (low_cycles) begin
      @(negedge clk);
      chk("wait_busy", busy[0], 1);
      chk("wait_no_valid", m_valid[0] | m_valid[1], 0);
    end
    @(posedge clk); #1 fht_rdy = 1'b1;
  endtask

  initial begin
    int r1, r4;
`ifdef FHT_SEQ_BITREV_EN
    rtab = '{0, 4, 2, 6, 1, 5, 3, 7};
    r1 = 4; r4 = 1;
`else
    rtab = '{0, 1, 2, 3, 4, 5, 6, 7};
    r1 = 1; r4 = 4;
`endif
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_s_ready", s_ready[g], 0);
      chk("rst_we", we[g], 0);
      chk("rst_start", start[g], 0);
      chk("rst_m_valid", m_valid[g], 0);
      chk("rst_m_last", m_last[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_fdata", fdata[g], 0);
      chk("rst_addr_wr", awr[g], 0);
      chk("rst_addr_rd", ard[g], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_before_clk", s_ready[0], 0);
    @(posedge clk); #1;
    chk("ready_after_clk", s_ready[0], 1);

    // Frame 1: ramp, done level already high at START, full rate
    for (int n = 0; n < N; n++) sent[n] = D'(n);
    build_exp();
    fht_rdy = 1'b1;
    full_rate[0] = 1'b1;
    send(0, N);
    chk("ready_drop", s_ready[0], 0);
    repeat (6) begin
      @(negedge clk);
      chk("hold_busy", busy[0], 1);
      chk("hold_no_valid", m_valid[0] | m_valid[1], 0);
    end
    rdy_pulse(10);
    wait_frames(1);
    chk("starts_f1", starts[0], 1);

    // Frame 2: bank i addr a holds 100*i+a, stalled downstream
    for (int n = 0; n < N; n++) sent[n] = D'(100 * (n % 4) + n / 4);
    build_exp();
    full_rate[0] = 1'b0;
    @(posedge clk); #1;
    send(0, N);
    stall_mode = 1'b1;
    rdy_pulse(3);
    wait_frames(2);
    stall_mode = 1'b0;
    chk("f2_k0", got[0][0], 0);
    chk("f2_k1", got[0][1], 100);
    chk("f2_k2", got[0][2], 200);
    chk("f2_k3", got[0][3], 300);
    chk("f2_k4", got[0][4], r1);
    chk("f2_k5", got[0][5], 100 + r1);
    chk("f2_k16", got[0][16], r4);
    chk("f2_k31", got[0][31], 307);
    chk("f2_lat3_k4", got[1][4], r1);

    // Frame 3: reset with 17 samples loaded, then a fresh full frame
    for (int n = 0; n < N; n++) sent[n] = D'(1000 + n);
    build_exp();
    full_rate[0] = 1'b1;
    @(posedge clk); #1;
    send(0, 17);
    chk("pre_rst_we", we[0], 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready[0], 0);
    chk("mid_rst_we", we[0], 0);
    chk("mid_rst_fdata", fdata[0], 0);
    chk("mid_rst_addr_wr", awr[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, N - 1);
    repeat (2) begin
      @(negedge clk);
      chk("no_start_31", starts[0], 1 + frames[0] - 1);
      chk("no_busy_31", busy[0], 0);
    end
    @(posedge clk); #1;
    send(N - 1, N);
    rdy_pulse(4);
    wait_frames(3);
    chk("starts_f3", starts[0], 3);
    chk("starts_f3_lat3", starts[1], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
